// File: rtl/lif_spike_stage.sv
// LIF spike stage: one register stage that turns an updated membrane potential into a
// write-back value and, on threshold crossing, a queued spike event with refractory tracking.
module lif_spike_stage #(
    parameter int ID_W       = 4,
    parameter int REF_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ID_W-1:0] in_id,
    input  logic [31:0]     in_v,
    input  logic [31:0]     v_th,
    input  logic [31:0]     v_reset,
    input  logic [REF_W-1:0] refrac_len,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [ID_W-1:0] wb_id,
    output logic [31:0]     wb_v,
    output logic            spike_valid,
    input  logic            spike_ready,
    output logic [ID_W-1:0] spike_id,
    output logic [15:0]     spike_count
);
    localparam int NUM_N = 1 << ID_W;
    localparam int AW    = $clog2(FIFO_DEPTH);

    // Map a float onto an unsigned key whose integer order matches float order.
    // Exponent-0 values collapse to +0 so that -0 == +0.
    function automatic logic [31:0] fp_key(input logic [31:0] f);
        logic [30:0] mag;
        mag = (f[30:23] == 8'h00) ? '0 : f[30:0];
        if (f[31] && mag != '0) fp_key = 32'h7FFF_FFFF - {1'b0, mag};
        else                    fp_key = 32'h8000_0000 + {1'b0, mag};
    endfunction

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != '0);
    endfunction

    logic             s1_valid;
    logic [ID_W-1:0]  s1_id;
    logic [31:0]      s1_v;
    logic [REF_W-1:0] refrac [NUM_N];

    logic [ID_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             fifo_full, fifo_empty, push, pop;

    logic             in_refrac, v_ge, fire, blocked, retire;

    assign in_refrac = refrac[s1_id] != '0;
    assign v_ge      = !is_nan(s1_v) && !is_nan(v_th) && (fp_key(s1_v) >= fp_key(v_th));
    assign fire      = !in_refrac && v_ge;

    assign fifo_empty = wr_ptr == rd_ptr;
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign blocked  = fire && fifo_full;
    assign wb_valid = s1_valid && !blocked;
    assign retire   = wb_valid && wb_ready;
    assign in_ready = !s1_valid || retire;

    assign wb_id = s1_id;
    // Gated by s1_valid so the bus reads zero when idle and out of reset.
    assign wb_v  = !s1_valid ? '0 : ((fire || in_refrac) ? v_reset : s1_v);

    // A retiring FIRE implies the FIFO was not full, so push never overflows.
    assign push        = retire && fire;
    assign pop         = spike_valid && spike_ready;
    assign spike_valid = !fifo_empty;
    assign spike_id    = fifo_empty ? '0 : fifo_mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_id    <= '0;
            s1_v     <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            s1_id    <= in_id;
            s1_v     <= in_v;
        end else if (retire) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_N; i++) refrac[i] <= '0;
        end else if (retire) begin
            if (fire)           refrac[s1_id] <= refrac_len;
            else if (in_refrac) refrac[s1_id] <= refrac[s1_id] - REF_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            spike_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push && spike_count != 16'hFFFF) spike_count <= spike_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= s1_id;
    end

endmodule

// File: tb/tb_lif_spike_stage.sv
// Directed bench for lif_spike_stage: hand-computed vectors for pass/fire/refractory,
// float compare corner cases, FIFO backpressure, write-back stall and mid-stall reset.
module tb_lif_spike_stage;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [3:0]  in_id;
    logic [31:0] in_v, v_th, v_reset;
    logic [3:0]  refrac_len;
    logic        wb_valid, wb_ready;
    logic [3:0]  wb_id;
    logic [31:0] wb_v;
    logic        spike_valid, spike_ready;
    logic [3:0]  spike_id;
    logic [15:0] spike_count;

    int tests = 0;
    int fails = 0;

    lif_spike_stage #(.ID_W(4), .REF_W(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_v(in_v),
        .v_th(v_th), .v_reset(v_reset), .refrac_len(refrac_len),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_id(wb_id), .wb_v(wb_v),
        .spike_valid(spike_valid), .spike_ready(spike_ready), .spike_id(spike_id),
        .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one input for a single edge; afterwards it sits in S1.
    task automatic send(input logic [3:0] id, input logic [31:0] v);
        in_id    = id;
        in_v     = v;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic pop_one();
        spike_ready = 1'b1;
        tick();
        spike_ready = 1'b0;
    endtask

    localparam logic [31:0] VTH  = 32'hC248_0000;
    localparam logic [31:0] VRST = 32'hC282_0000;

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; in_id = '0; in_v = '0;
        v_th = VTH; v_reset = VRST; refrac_len = 4'd2;
        wb_ready = 1'b1; spike_ready = 1'b0;
        #12;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_spike_valid", spike_valid, 0);
        chk("rst_count", spike_count, 0);
        chk("rst_wb_id", wb_id, 0);
        chk("rst_wb_v", wb_v, 0);
        chk("rst_spike_id", spike_id, 0);
        reset_n = 1'b1;
        tick();
        chk("rel_in_ready", in_ready, 1);

        // Below threshold: pass-through
        send(4'd3, 32'hC275_0000);
        chk("pass_wb_valid", wb_valid, 1);
        chk("pass_wb_id", wb_id, 3);
        chk("pass_wb_v", wb_v, 32'hC275_0000);
        tick();
        chk("pass_no_spike", spike_valid, 0);
        chk("pass_count", spike_count, 0);
        chk("pass_drained", wb_valid, 0);

        // Fire then two refractory updates then fire again
        send(4'd5, 32'hC240_0000);
        chk("fire_wb_v", wb_v, VRST);
        tick();
        chk("fire_spike_valid", spike_valid, 1);
        chk("fire_spike_id", spike_id, 5);
        chk("fire_count", spike_count, 1);
        pop_one();
        chk("fire_popped", spike_valid, 0);
        for (int k = 0; k < 2; k++) begin
            send(4'd5, 32'hC220_0000);
            chk("refrac_wb_v", wb_v, VRST);
            tick();
            chk("refrac_no_spike", spike_valid, 0);
            chk("refrac_count", spike_count, 1);
        end
        send(4'd5, 32'hC220_0000);
        chk("refire_wb_v", wb_v, VRST);
        tick();
        chk("refire_spike_id", spike_id, 5);
        chk("refire_count", spike_count, 2);
        pop_one();

        // Float compare corners
        send(4'd7, VTH);
        chk("eq_th_wb_v", wb_v, VRST);
        tick();
        chk("eq_th_count", spike_count, 3);
        pop_one();
        send(4'd8, 32'h7FC0_0000);
        chk("nan_wb_v", wb_v, 32'h7FC0_0000);
        tick();
        chk("nan_count", spike_count, 3);
        chk("nan_no_spike", spike_valid, 0);
        v_th = 32'h0000_0000;
        send(4'd9, 32'h8000_0000);
        chk("negzero_wb_v", wb_v, VRST);
        tick();
        chk("negzero_count", spike_count, 4);
        pop_one();
        send(4'd10, 32'h7F80_0000);
        tick();
        chk("inf_count", spike_count, 5);
        pop_one();
        send(4'd12, 32'hBF80_0000);
        chk("neg1_vs_0_wb_v", wb_v, 32'hBF80_0000);
        tick();
        chk("neg1_vs_0_count", spike_count, 5);

        // FIFO full backpressure
        v_th = VTH; refrac_len = 4'd0;
        for (int k = 1; k <= 4; k++) begin
            send(4'(k), 32'h0000_0000);
            tick();
        end
        chk("full_count", spike_count, 9);
        send(4'd6, 32'h0000_0000);
        chk("blk_wb_valid", wb_valid, 0);
        chk("blk_in_ready", in_ready, 0);
        tick();
        chk("blk_wb_valid2", wb_valid, 0);
        chk("blk_head", spike_id, 1);
        spike_ready = 1'b1;
        tick();
        chk("unblk_wb_valid", wb_valid, 1);
        chk("unblk_wb_id", wb_id, 6);
        chk("pop2_id", spike_id, 2);
        tick();
        chk("pop3_id", spike_id, 3);
        chk("id6_retired", wb_valid, 0);
        tick();
        chk("pop4_id", spike_id, 4);
        tick();
        chk("pop6_id", spike_id, 6);
        tick();
        chk("fifo_drained", spike_valid, 0);
        chk("after_full_count", spike_count, 10);
        spike_ready = 1'b0;

        // Queue one spike, then stall write-back, then reset mid-stall
        send(4'd11, 32'h0000_0000);
        tick();
        chk("queued_spike", spike_id, 11);
        wb_ready = 1'b0;
        send(4'd2, 32'h0000_0000);
        for (int k = 0; k < 3; k++) begin
            chk("stall_wb_valid", wb_valid, 1);
            chk("stall_wb_id", wb_id, 2);
            chk("stall_wb_v", wb_v, VRST);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_count", spike_count, 11);
            tick();
        end
        reset_n = 1'b0;
        #1;
        chk("mrst_wb_valid", wb_valid, 0);
        chk("mrst_wb_v", wb_v, 0);
        chk("mrst_wb_id", wb_id, 0);
        chk("mrst_spike_valid", spike_valid, 0);
        chk("mrst_spike_id", spike_id, 0);
        chk("mrst_count", spike_count, 0);
        chk("mrst_in_ready", in_ready, 1);
        wb_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1);
        // id 7 was left refractory before reset; cleared refrac means it fires now
        send(4'd7, 32'h0000_0000);
        tick();
        chk("post_rst_refrac_clear", spike_count, 1);
        chk("post_rst_spike_id", spike_id, 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
